// File: rtl/uint_to_float_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : uint_to_float_pipe_if
//  Purpose  : Valid/ready input and output channels of the integer to
//             IEEE-754 single-precision converter.
//  Revision : 1.0  initial release
// ============================================================================
interface uint_to_float_pipe_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_float;

    // Converter side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_float
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_float
    );
endinterface
`default_nettype wire

// File: rtl/uint_to_float_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : uint_to_float_pipe
//  Purpose  : Three-stage pipelined integer / fixed-point to IEEE-754 single
//             conversion with round-to-nearest-even and valid/ready flow.
//             S1 sign/magnitude, S2 leading-one detect + normalise,
//             S3 round + pack.
//  Revision : 1.0  initial release
// ============================================================================
module uint_to_float_pipe #(
    parameter int WIDTH     = 16,
    parameter int SIGNED    = 0,
    parameter int FRAC_BITS = 0
) (
    input  logic                clk,
    input  logic                reset,
    uint_to_float_pipe_if.slave bus
);
    // Magnitude carries one extra bit so the most negative input negates exactly.
    localparam int         MW    = WIDTH + 1;
    // Normalised magnitude extended with zeros so a 23-bit mantissa plus
    // guard/round/sticky can always be sliced, whatever WIDTH is.
    localparam int         EW    = MW + 26;
    localparam logic [5:0] C_TOP  = 6'(MW - 1);
    localparam logic [7:0] C_FRAC = 8'(FRAC_BITS);

    logic          adv;
    logic          v1_q, v2_q, v3_q;

    logic          sign1_d, sign1_q;
    logic [MW-1:0] mag1_d,  mag1_q;

    logic [5:0]    lead;
    logic [5:0]    shamt;
    logic          sign2_q;
    logic [7:0]    exp2_d,  exp2_q;
    logic [MW-1:0] norm2_d, norm2_q;

    logic [EW-1:0] ext;
    logic [22:0]   frac;
    logic          guard, rnd, sticky, round_up, carry;
    logic [22:0]   mant;
    logic [7:0]    exp3;
    logic [31:0]   float_d, float_q;

    // The whole pipeline moves together whenever the output slot is free or drained.
    assign adv           = !v3_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = v3_q;
    assign bus.out_float = float_q;

    // S1: split sign and magnitude; negation done in WIDTH+1 bits.
    always_comb begin
        sign1_d = 1'b0;
        mag1_d  = {1'b0, bus.in_data};
        if (SIGNED != 0 && bus.in_data[WIDTH-1]) begin
            sign1_d = 1'b1;
            mag1_d  = (~{bus.in_data[WIDTH-1], bus.in_data}) + {{WIDTH{1'b0}}, 1'b1};
        end
    end

    // S2: find the leading one and shift it to the top of the magnitude.
    // A zero magnitude leaves the top bit clear, which S3 uses as the zero flag.
    always_comb begin
        lead = 6'd0;
        for (int i = 0; i < MW; i++) begin
            if (mag1_q[i]) begin
                lead = 6'(i);
            end
        end
        shamt   = C_TOP - lead;
        norm2_d = mag1_q << shamt;
        // Result always lies within 0..255 for legal parameters, so 8-bit wrap is exact.
        exp2_d  = 8'd127 + {2'b00, lead} - C_FRAC;
    end

    // S3: round to nearest even on guard/round/sticky and pack the fields.
    always_comb begin
        ext      = {norm2_q, 26'd0};
        frac     = ext[EW-2 -: 23];
        guard    = ext[MW+1];
        rnd      = ext[MW];
        sticky   = |ext[MW-1:0];
        round_up = guard & (rnd | sticky | frac[0]);
        // Carry out of the 23-bit field means 1.111..1 rounded up to 10.000..0.
        {carry, mant} = {1'b0, frac} + {23'd0, round_up};
        exp3     = exp2_q + {7'd0, carry};
        float_d  = ext[EW-1] ? {sign2_q, exp3, mant} : 32'd0;
    end

    // Stage valid flags and the output word; cleared by reset, frozen on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            float_q <= 32'd0;
        end else if (adv) begin
            v1_q <= bus.in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (v2_q) begin
                float_q <= float_d;
            end
        end
    end

    // Intermediate stage payloads; only loaded when a valid sample moves in.
    always_ff @(posedge clk) begin
        if (adv && bus.in_valid) begin
            sign1_q <= sign1_d;
            mag1_q  <= mag1_d;
        end
        if (adv && v1_q) begin
            sign2_q <= sign1_q;
            exp2_q  <= exp2_d;
            norm2_q <= norm2_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uint_to_float_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uint_to_float_pipe
//  Purpose  : Self-checking bench for uint_to_float_pipe in four parameter
//             configurations against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uint_to_float_pipe;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // d=0: 16u, d=1: 32u, d=2: 16 signed, d=3: 16u with 8 fraction bits
    uint_to_float_pipe_if #(.WIDTH(16)) bu16 ();
    uint_to_float_pipe_if #(.WIDTH(32)) bu32 ();
    uint_to_float_pipe_if #(.WIDTH(16)) bs16 ();
    uint_to_float_pipe_if #(.WIDTH(16)) bf16 ();

    uint_to_float_pipe #(.WIDTH(16), .SIGNED(0), .FRAC_BITS(0)) u_u16 (.clk(clk), .reset(reset), .bus(bu16));
    uint_to_float_pipe #(.WIDTH(32), .SIGNED(0), .FRAC_BITS(0)) u_u32 (.clk(clk), .reset(reset), .bus(bu32));
    uint_to_float_pipe #(.WIDTH(16), .SIGNED(1), .FRAC_BITS(0)) u_s16 (.clk(clk), .reset(reset), .bus(bs16));
    uint_to_float_pipe #(.WIDTH(16), .SIGNED(0), .FRAC_BITS(8)) u_f16 (.clk(clk), .reset(reset), .bus(bf16));

    int cfg_w [4] = '{16, 32, 16, 16};
    int cfg_s [4] = '{0, 0, 1, 0};
    int cfg_f [4] = '{0, 0, 0, 8};

    // Reference: exact value, then round the quotient by comparing the remainder to half an ulp.
    function automatic logic [31:0] ref_conv(input longint unsigned raw, input int width,
                                             input int sgn, input int fbits);
        longint unsigned mag, q, rem, half;
        bit s;
        int p, e, sh;
        raw = raw & ((64'd1 << width) - 64'd1);
        s   = 1'b0;
        mag = raw;
        if (sgn != 0 && raw >= (64'd1 << (width - 1))) begin
            s   = 1'b1;
            mag = (64'd1 << width) - raw;
        end
        if (mag == 0) return 32'h0000_0000;
        p = 0;
        for (int i = 0; i < 40; i++) if (mag >= (64'd1 << i)) p = i;
        e = 127 + p - fbits;
        if (p <= 23) begin
            q = mag << (23 - p);
        end else begin
            sh   = p - 23;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        return {s, 8'(e), 23'(q)};
    endfunction

    task automatic drive(input int d, input bit v, input logic [31:0] data);
        case (d)
            0: begin bu16.in_valid = v; bu16.in_data = data[15:0]; end
            1: begin bu32.in_valid = v; bu32.in_data = data;       end
            2: begin bs16.in_valid = v; bs16.in_data = data[15:0]; end
            default: begin bf16.in_valid = v; bf16.in_data = data[15:0]; end
        endcase
    endtask

    function automatic logic [33:0] obs(input int d);
        case (d)
            0: return {bu16.in_ready, bu16.out_valid, bu16.out_float};
            1: return {bu32.in_ready, bu32.out_valid, bu32.out_float};
            2: return {bs16.in_ready, bs16.out_valid, bs16.out_float};
            default: return {bf16.in_ready, bf16.out_valid, bf16.out_float};
        endcase
    endfunction

    task automatic set_out_ready(input bit r);
        bu16.out_ready = r; bu32.out_ready = r; bs16.out_ready = r; bf16.out_ready = r;
    endtask

    task automatic test_reset();
        logic [33:0] o;
        for (int d = 0; d < 4; d++) drive(d, 1'b0, 32'd0);
        set_out_ready(1'b0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            o = obs(d);
            total++;
            if (o[32] !== 1'b0 || o[31:0] !== 32'h0) begin
                bad++;
                $display("FAIL reset_state[%0d]: got valid=%b float=%h, want valid=0 float=00000000", d, o[32], o[31:0]);
            end
        end
        reset = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            o = obs(d);
            total++;
            if (o[33] !== 1'b1) begin
                bad++;
                $display("FAIL reset_in_ready[%0d]: got %b, want 1", d, o[33]);
            end
        end
        set_out_ready(1'b1);
    endtask

    // Back-to-back stream with out_ready high: first result 3 cycles after the first input.
    task automatic run_stream(input int d, input string name, input logic [31:0] vec[$]);
        logic [33:0] o;
        logic [31:0] exp_q[$];
        foreach (vec[i]) exp_q.push_back(ref_conv(64'(vec[i]), cfg_w[d], cfg_s[d], cfg_f[d]));
        for (int c = 0; c < vec.size() + 3; c++) begin
            @(negedge clk);
            o = obs(d);
            total++;
            if (c >= 3) begin
                if (o[32] !== 1'b1 || o[31:0] !== exp_q[c-3]) begin
                    bad++;
                    $display("FAIL %s[%0d] in=%h: got valid=%b float=%h, want valid=1 float=%h",
                             name, c - 3, vec[c-3], o[32], o[31:0], exp_q[c-3]);
                end
            end else if (o[32] !== 1'b0) begin
                bad++;
                $display("FAIL %s_latency[%0d]: got valid=%b, want 0", name, c, o[32]);
            end
            if (c < vec.size()) drive(d, 1'b1, vec[c]);
            else                drive(d, 1'b0, 32'd0);
        end
        @(negedge clk);
    endtask

    task automatic test_u16_stream();
        logic [31:0] v[$];
        v = '{32'h0000, 32'h0001, 32'hFFFF, 32'h8000, 32'h00FF};
        for (int i = 0; i < 30; i++) v.push_back($urandom() & 32'hFFFF);
        run_stream(0, "u16_stream", v);
    endtask

    task automatic test_u32_rounding();
        logic [31:0] v[$];
        v = '{32'hFFFFFFFF, 32'h01000001, 32'h01000003, 32'h00FFFFFF, 32'h01000002, 32'h80000000};
        for (int i = 0; i < 30; i++) v.push_back($urandom());
        run_stream(1, "u32_round", v);
    endtask

    task automatic test_signed();
        logic [31:0] v[$];
        v = '{32'h8000, 32'hFFFF, 32'h7FFF, 32'h0000, 32'h0001};
        for (int i = 0; i < 30; i++) v.push_back($urandom() & 32'hFFFF);
        run_stream(2, "s16", v);
    endtask

    task automatic test_frac();
        logic [31:0] v[$];
        v = '{32'h0180, 32'h0001, 32'h0000, 32'hFFFF};
        for (int i = 0; i < 30; i++) v.push_back($urandom() & 32'hFFFF);
        run_stream(3, "frac8", v);
    endtask

    task automatic test_backpressure();
        logic [31:0] sb[$];
        logic [31:0] held, data, e;
        bit stalled = 1'b0;
        int sent = 0;
        int cyc  = 0;
        while ((sent < 10000 || sb.size() > 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                total++;
                if (bu16.out_valid !== 1'b1 || bu16.out_float !== held) begin
                    bad++;
                    $display("FAIL bp_stall: got valid=%b float=%h, want valid=1 float=%h",
                             bu16.out_valid, bu16.out_float, held);
                end
            end
            data = $urandom() & 32'hFFFF;
            drive(0, (sent < 10000) && ($urandom_range(0, 3) != 0), data);
            bu16.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bu16.in_valid && bu16.in_ready) begin
                sb.push_back(ref_conv(64'(data), 16, 0, 0));
                sent++;
            end
            if (bu16.out_valid && bu16.out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL bp_extra: got float=%h, want no output", bu16.out_float);
                end else begin
                    e = sb.pop_front();
                    if (bu16.out_float !== e) begin
                        bad++;
                        $display("FAIL bp_data: got %h, want %h", bu16.out_float, e);
                    end
                end
            end
            stalled = bu16.out_valid && !bu16.out_ready;
            held    = bu16.out_float;
        end
        total++;
        if (sent != 10000 || sb.size() != 0) begin
            bad++;
            $display("FAIL bp_timeout: got sent=%0d pending=%0d, want sent=10000 pending=0", sent, sb.size());
        end
        drive(0, 1'b0, 32'd0);
        bu16.out_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_in_flight();
        logic [31:0] vals[3] = '{32'h1234, 32'h2345, 32'h3456};
        @(negedge clk);
        bu16.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, vals[k]);
            @(negedge clk);
        end
        drive(0, 1'b0, 32'd0);
        total++;
        if (bu16.out_valid !== 1'b1 || bu16.out_float !== ref_conv(64'h1234, 16, 0, 0)) begin
            bad++;
            $display("FAIL rif_fill: got valid=%b float=%h, want valid=1 float=%h",
                     bu16.out_valid, bu16.out_float, ref_conv(64'h1234, 16, 0, 0));
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (bu16.out_valid !== 1'b0 || bu16.out_float !== 32'h0) begin
            bad++;
            $display("FAIL rif_cleared: got valid=%b float=%h, want valid=0 float=00000000",
                     bu16.out_valid, bu16.out_float);
        end
        reset = 1'b0;
        #1;
        total++;
        if (bu16.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rif_in_ready: got %b, want 1", bu16.in_ready);
        end
        bu16.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            total++;
            if (bu16.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL rif_ghost[%0d]: got valid=1 float=%h, want valid=0", c, bu16.out_float);
            end
        end
    endtask

    initial begin
        test_reset();
        test_u16_stream();
        test_u32_rounding();
        test_signed();
        test_frac();
        test_backpressure();
        test_reset_in_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
